// File: rtl/cache_line_fill.sv
// Cache line fill engine: fetches a whole line critical-word-first through a
// single-word read port, writes the data RAM and brackets the fill with tag writes.
module cache_line_fill #(
  parameter  int LINE_WORDS = 4,
  parameter  int INDEX_W    = 6,
  localparam int OFFSET_W   = $clog2(LINE_WORDS),
  localparam int TAG_W      = 30 - INDEX_W - OFFSET_W
) (
  input  logic                        i_hclk,
  input  logic                        i_hreset,
  input  logic                        i_fill_req,
  input  logic [29:0]                 i_fill_addr,
  output logic                        o_fill_busy,
  output logic                        o_fill_done,
  output logic                        o_crit_valid,
  output logic [31:0]                 o_crit_data,
  output logic                        o_mem_sel,
  output logic [29:0]                 o_mem_addr,
  input  logic [31:0]                 i_mem_rdata,
  input  logic                        i_mem_ready,
  output logic                        o_dram_we,
  output logic [INDEX_W+OFFSET_W-1:0] o_dram_addr,
  output logic [31:0]                 o_dram_wdata,
  output logic                        o_tram_we,
  output logic [INDEX_W-1:0]          o_tram_addr,
  output logic [TAG_W:0]              o_tram_wdata
);

  typedef enum logic [2:0] {IDLE, INVAL, ADDR, DATA, COMMIT} state_t;

  localparam logic [OFFSET_W-1:0] LAST = OFFSET_W'(LINE_WORDS - 1);

  state_t              state, next;
  logic [TAG_W-1:0]    tag;
  logic [INDEX_W-1:0]  index;
  logic [OFFSET_W-1:0] cur_off, cnt;
  logic                accept;

  assign accept = (state == DATA) && i_mem_ready;

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state   <= IDLE;
      tag     <= '0;
      index   <= '0;
      cur_off <= '0;
      cnt     <= '0;
    end else begin
      state <= next;
      if (state == IDLE && i_fill_req) begin
        {tag, index, cur_off} <= i_fill_addr;
        cnt                   <= '0;
      end else if (accept) begin
        // offset wraps naturally at the line boundary
        cur_off <= cur_off + 1'b1;
        cnt     <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (i_fill_req) next = INVAL;
      INVAL:   next = ADDR;
      ADDR:    if (i_mem_ready) next = DATA;
      DATA:    if (i_mem_ready) next = (cnt == LAST) ? COMMIT : ADDR;
      COMMIT:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Outputs forced low while reset is asserted, even mid-fill.
  always_comb begin
    o_fill_busy  = 1'b0;
    o_fill_done  = 1'b0;
    o_crit_valid = 1'b0;
    o_crit_data  = '0;
    o_mem_sel    = 1'b0;
    o_mem_addr   = '0;
    o_dram_we    = 1'b0;
    o_dram_addr  = '0;
    o_dram_wdata = '0;
    o_tram_we    = 1'b0;
    o_tram_addr  = '0;
    o_tram_wdata = '0;
    if (!i_hreset) begin
      case (state)
        INVAL: begin
          o_fill_busy  = 1'b1;
          o_tram_we    = 1'b1;
          o_tram_addr  = index;
          o_tram_wdata = {1'b0, tag};
        end
        ADDR: begin
          o_fill_busy = 1'b1;
          o_mem_sel   = 1'b1;
          o_mem_addr  = {tag, index, cur_off};
        end
        DATA: begin
          o_fill_busy = 1'b1;
          o_mem_addr  = {tag, index, cur_off};
          if (i_mem_ready) begin
            o_dram_we    = 1'b1;
            o_dram_addr  = {index, cur_off};
            o_dram_wdata = i_mem_rdata;
            if (cnt == '0) begin
              o_crit_valid = 1'b1;
              o_crit_data  = i_mem_rdata;
            end
          end
        end
        COMMIT: begin
          o_fill_busy  = 1'b1;
          o_fill_done  = 1'b1;
          o_tram_we    = 1'b1;
          o_tram_addr  = index;
          o_tram_wdata = {1'b1, tag};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_fill.sv
// Bench for cache_line_fill: two instances (4- and 8-word lines) share stimulus;
// a step-indexed fill model checks both every cycle, plus literal cycle checks.
module tb_cache_line_fill;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        hreset, fill_req, mem_ready;
  logic [29:0] fill_addr;

  logic        busy4, done4, cv4, sel4, dwe4, twe4;
  logic [31:0] cd4, dwd4, rd4;
  logic [29:0] ma4;
  logic [7:0]  da4;
  logic [5:0]  ta4;
  logic [22:0] tw4;

  logic        busy8, done8, cv8, sel8, dwe8, twe8;
  logic [31:0] cd8, dwd8, rd8;
  logic [29:0] ma8;
  logic [8:0]  da8;
  logic [5:0]  ta8;
  logic [21:0] tw8;

  // Memory returns a tag pattern of the address it was asked for.
  assign rd4 = 32'hA000_0000 | {2'b00, ma4};
  assign rd8 = 32'hA000_0000 | {2'b00, ma8};

  cache_line_fill #(.LINE_WORDS(4), .INDEX_W(6)) dut4 (
    .i_hclk(clk), .i_hreset(hreset), .i_fill_req(fill_req), .i_fill_addr(fill_addr),
    .o_fill_busy(busy4), .o_fill_done(done4), .o_crit_valid(cv4), .o_crit_data(cd4),
    .o_mem_sel(sel4), .o_mem_addr(ma4), .i_mem_rdata(rd4), .i_mem_ready(mem_ready),
    .o_dram_we(dwe4), .o_dram_addr(da4), .o_dram_wdata(dwd4),
    .o_tram_we(twe4), .o_tram_addr(ta4), .o_tram_wdata(tw4));

  cache_line_fill #(.LINE_WORDS(8), .INDEX_W(6)) dut8 (
    .i_hclk(clk), .i_hreset(hreset), .i_fill_req(fill_req), .i_fill_addr(fill_addr),
    .o_fill_busy(busy8), .o_fill_done(done8), .o_crit_valid(cv8), .o_crit_data(cd8),
    .o_mem_sel(sel8), .o_mem_addr(ma8), .i_mem_rdata(rd8), .i_mem_ready(mem_ready),
    .o_dram_we(dwe8), .o_dram_addr(da8), .o_dram_wdata(dwd8),
    .o_tram_we(twe8), .o_tram_addr(ta8), .o_tram_wdata(tw8));

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Fill model: step 0 = tag invalidate, steps 1..2L alternate request/data
  // for word k (advance only with ready), step 2L+1 = commit.
  bit          mact [2];
  int          mstep[2];
  logic [29:0] maddr[2];

  task automatic check_dut(input int d, input int L,
                           input logic b, input logic dn, input logic cv, input logic [31:0] cd,
                           input logic sl, input logic [29:0] ma, input logic dw,
                           input logic [31:0] daddr, input logic [31:0] dwd,
                           input logic twe, input logic [31:0] taddr, input logic [31:0] twd);
    int a, off0, idx, tg, tbits, s, k, woff;
    logic [31:0] e_b, e_dn, e_cv, e_cd, e_sl, e_ma, e_dw, e_da, e_dwd, e_twe, e_ta, e_twd;
    string p;
    p = (L == 4) ? "m4" : "m8";
    a = int'(maddr[d]);
    off0 = a % L;
    idx = (a / L) % 64;
    tg = a / (L * 64);
    tbits = (L == 4) ? 22 : 21;
    {e_b, e_dn, e_cv, e_cd, e_sl, e_ma} = '0;
    {e_dw, e_da, e_dwd, e_twe, e_ta, e_twd} = '0;
    if (!hreset && mact[d]) begin
      s = mstep[d];
      e_b = 1;
      if (s == 0) begin
        e_twe = 1; e_ta = idx; e_twd = tg;
      end else if (s == 2 * L + 1) begin
        e_dn = 1; e_twe = 1; e_ta = idx; e_twd = (1 << tbits) | tg;
      end else begin
        k = (s - 1) / 2;
        woff = (off0 + k) % L;
        e_ma = a - off0 + woff;
        if (s % 2 == 1) e_sl = 1;
        else if (mem_ready) begin
          e_dw = 1; e_da = idx * L + woff; e_dwd = 32'hA000_0000 | e_ma;
          if (k == 0) begin e_cv = 1; e_cd = e_dwd; end
        end
      end
    end
    chk({p, "_busy"}, 32'(b), e_b);
    chk({p, "_done"}, 32'(dn), e_dn);
    chk({p, "_crit_valid"}, 32'(cv), e_cv);
    chk({p, "_crit_data"}, cd, e_cd);
    chk({p, "_mem_sel"}, 32'(sl), e_sl);
    chk({p, "_mem_addr"}, 32'(ma), e_ma);
    chk({p, "_dram_we"}, 32'(dw), e_dw);
    chk({p, "_dram_addr"}, daddr, e_da);
    chk({p, "_dram_wdata"}, dwd, e_dwd);
    chk({p, "_tram_we"}, 32'(twe), e_twe);
    chk({p, "_tram_addr"}, taddr, e_ta);
    chk({p, "_tram_wdata"}, twd, e_twd);
  endtask

  task automatic model_step(input int d, input int L);
    if (hreset) mact[d] = 0;
    else if (!mact[d]) begin
      if (fill_req) begin mact[d] = 1; mstep[d] = 0; maddr[d] = fill_addr; end
    end else if (mstep[d] == 2 * L + 1) mact[d] = 0;
    else if (mstep[d] == 0 || mem_ready) mstep[d]++;
  endtask

  always @(negedge clk) begin
    check_dut(0, 4, busy4, done4, cv4, cd4, sel4, ma4, dwe4, 32'(da4), dwd4, twe4, 32'(ta4), 32'(tw4));
    check_dut(1, 8, busy8, done8, cv8, cd8, sel8, ma8, dwe8, 32'(da8), dwd8, twe8, 32'(ta8), 32'(tw8));
    model_step(0, 4);
    model_step(1, 8);
  end

  // Inputs for relative cycle c of test id (cycle 0 = request sampled).
  task automatic drive(input int id, input int c);
    fill_req = 1'b0; mem_ready = 1'b1; hreset = 1'b0;
    case (id)
      1, 2, 3, 4: if (c == 0) begin fill_req = 1'b1; fill_addr = 30'h123; end
      5: begin fill_req = (c <= 20); fill_addr = 30'h040; end
      6: if (c == 0) begin fill_req = 1'b1; fill_addr = 30'h0AF; end
      default: ;
    endcase
    if (id == 2) mem_ready = !(c == 2 || c == 3 || c == 5 || c == 6 || c == 7);
    if (id == 3 && c == 5) begin fill_req = 1'b1; fill_addr = 30'h3FF; end
    if (id == 4 && c == 6) hreset = 1'b1;
    if (id == 4 && c == 8) begin fill_req = 1'b1; fill_addr = 30'h040; end
  endtask

  // Hand-computed expectations that pin the model.
  task automatic lit(input int id, input int c);
    case (id)
      1: begin
        if (c == 1) begin
          chk("t1_inval_we", 32'(twe4), 1); chk("t1_inval_idx", 32'(ta4), 32'h08);
          chk("t1_inval_wd", 32'(tw4), 32'h1);
        end
        if (c == 2) chk("t1_addr0", 32'(ma4), 32'h123);
        if (c == 4) chk("t1_addr1", 32'(ma4), 32'h120);
        if (c == 6) chk("t1_addr2", 32'(ma4), 32'h121);
        if (c == 8) chk("t1_addr3", 32'(ma4), 32'h122);
        if (c == 3) begin
          chk("t1_daddr0", 32'(da4), 32'h23); chk("t1_crit_v", 32'(cv4), 1);
          chk("t1_crit_d", cd4, 32'hA000_0123);
        end
        if (c == 5) begin chk("t1_daddr1", 32'(da4), 32'h20); chk("t1_crit_v_low", 32'(cv4), 0); end
        if (c == 7) chk("t1_daddr2", 32'(da4), 32'h21);
        if (c == 9) chk("t1_daddr3", 32'(da4), 32'h22);
        if (c == 10) begin
          chk("t1_done", 32'(done4), 1); chk("t1_commit_wd", 32'(tw4), 32'h40_0001);
        end
      end
      2: begin
        if (c == 2 || c == 3) begin
          chk("t2_sel_hold", 32'(sel4), 1); chk("t2_addr_hold", 32'(ma4), 32'h123);
        end
        if (c >= 5 && c <= 7) chk("t2_no_we", 32'(dwe4), 0);
        if (c == 8) chk("t2_crit_d", cd4, 32'hA000_0123);
        if (c == 14) chk("t2_done_early", 32'(done4), 0);
        if (c == 15) chk("t2_done", 32'(done4), 1);
      end
      3: begin
        if (c == 6) chk("t3_addr2", 32'(ma4), 32'h121);
        if (c == 8) chk("t3_addr3", 32'(ma4), 32'h122);
        if (c == 10) chk("t3_done", 32'(done4), 1);
        if (c == 12) chk("t3_idle", 32'(busy4), 0);
      end
      4: begin
        if (c == 7) begin
          chk("t4_busy", 32'(busy4), 0); chk("t4_tram_we", 32'(twe4), 0);
          chk("t4_done", 32'(done4), 0); chk("t4_sel", 32'(sel4), 0);
        end
        if (c == 9) begin
          chk("t4_reinval", 32'(twe4), 1); chk("t4_reinval_idx", 32'(ta4), 32'h10);
          chk("t4_reinval_wd", 32'(tw4), 0);
        end
        if (c == 18) chk("t4_done", 32'(done4), 1);
      end
      5: begin
        if (c == 10) chk("t5_done1", 32'(done4), 1);
        if (c == 11) chk("t5_gap", 32'(busy4), 0);
        if (c == 12) chk("t5_inval2", 32'(twe4), 1);
        if (c == 21) chk("t5_done2", 32'(done4), 1);
        if (c == 18) chk("t5_done8", 32'(done8), 1);
      end
      6: begin
        if (c == 2) chk("t6_addr0", 32'(ma8), 32'h0AF);
        if (c == 4) chk("t6_addr1", 32'(ma8), 32'h0A8);
        if (c == 16) chk("t6_addr7", 32'(ma8), 32'h0AE);
        if (c == 3) begin
          chk("t6_crit_d", cd8, 32'hA000_00AF); chk("t6_daddr0", 32'(da8), 32'h0AF);
        end
        if (c == 17) chk("t6_done_early", 32'(done8), 0);
        if (c == 18) chk("t6_done", 32'(done8), 1);
      end
      default: ;
    endcase
  endtask

  task automatic run(input int id, input int n);
    for (int c = 0; c < n; c++) begin
      drive(id, c);
      @(negedge clk);
      lit(id, c);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    fill_req = 1'b0; mem_ready = 1'b1; hreset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    hreset = 1'b1; fill_req = 1'b0; mem_ready = 1'b1; fill_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    idle(2);
    run(1, 13); idle(30);
    run(2, 17); idle(30);
    run(3, 13); idle(30);
    run(4, 20); idle(30);
    run(5, 25); idle(30);
    run(6, 20); idle(10);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cache_line_fill.md
Name: cache_line_fill

Overview:
- Miss-handling stage directly upstream of the cache's AHB-out read controller.
- On a miss request from the cache core, it fetches a full cache line word-by-word through the controller's single-word read interface, critical word first with wrap-around.
- Writes each returned word into the data RAM and forwards the critical word to the core.
- Invalidates the line's tag entry at fill start and marks it valid when the fill commits.

Parameters:
- LINE_WORDS, 4, words per cache line; power of 2, >=2. OFFSET_W = log2(LINE_WORDS) (localparam).
- INDEX_W, 6, line-index width. TAG_W = 30 - INDEX_W - OFFSET_W (localparam).

Ports:
- i_hclk  input  1  clock.
- i_hreset  input  1  synchronous active-high reset.
- i_fill_req  input  1  miss request; sampled only in IDLE.
- i_fill_addr  input  30  word address of the missing word; {tag, index, offset}.
- o_fill_busy  output  1  high from INVAL through COMMIT inclusive.
- o_fill_done  output  1  one-cycle pulse in COMMIT.
- o_crit_valid  output  1  one-cycle pulse when the critical (first) word returns.
- o_crit_data  output  32  critical word; valid only with o_crit_valid, else 0.
- o_mem_sel  output  1  read request to the AHB-out controller.
- o_mem_addr  output  30  word address of the current read.
- i_mem_rdata  input  32  read data from the controller.
- i_mem_ready  input  1  controller ready: accepts the request in ADDR, returns data in DATA.
- o_dram_we  output  1  data-RAM write strobe.
- o_dram_addr  output  INDEX_W+OFFSET_W  {index, offset}.
- o_dram_wdata  output  32  data-RAM write data.
- o_tram_we  output  1  tag-RAM write strobe.
- o_tram_addr  output  INDEX_W  line index.
- o_tram_wdata  output  TAG_W+1  {valid, tag}.

Behaviour:
- Single clock i_hclk. Reset i_hreset is synchronous and active-high.
- Reset: state IDLE, counters and latched address cleared. All outputs are 0 during reset and in IDLE.
- Outputs are combinational decodes of the registered state, latched address and counters. Exception: o_dram_wdata and o_crit_data pass i_mem_rdata through in the DATA-accept cycle.
- FSM states and transitions:
  - IDLE: if i_fill_req, latch i_fill_addr into tag/index/offset; cur_off := offset; cnt := 0; go to INVAL.
  - INVAL (1 cycle): o_tram_we=1, o_tram_addr=index, o_tram_wdata={1'b0, tag}; go to ADDR.
  - ADDR: o_mem_sel=1, o_mem_addr={tag, index, cur_off}. If i_mem_ready, go to DATA; else hold, with sel and addr stable.
  - DATA: o_mem_sel=0; o_mem_addr still driven. When i_mem_ready:
    - o_dram_we=1, o_dram_addr={index, cur_off}, o_dram_wdata=i_mem_rdata.
    - If cnt==0: o_crit_valid=1 and o_crit_data=i_mem_rdata.
    - cur_off := cur_off+1 mod LINE_WORDS (wraps); cnt := cnt+1.
    - Go to COMMIT if cnt==LINE_WORDS-1, else ADDR.
    - If i_mem_ready is low, wait with no writes.
  - COMMIT (1 cycle): o_tram_we=1, wdata={1'b1, tag}; o_fill_done=1; go to IDLE.
- Latency, zero wait states, request sampled in cycle 0:
  - INVAL in cycle 1; word k: ADDR in cycle 2+2k, DATA in cycle 3+2k.
  - COMMIT in cycle 2*LINE_WORDS+2, i.e. cycle 10 for LINE_WORDS=4.
  - Each wait cycle adds exactly one cycle.
- Word order: offset, offset+1, …, wrapping to 0.
  - Each offset is written exactly once per fill.
  - The tag entry is invalid for the whole fill, so a partial line never hits.
- i_fill_req outside IDLE is ignored, with no latch and no effect.
  - A request held high is re-sampled in the IDLE cycle after COMMIT, so the next INVAL occurs at COMMIT+2.
- Reset mid-fill: next cycle is IDLE with all outputs 0 and no COMMIT write. The tag stays invalid, which is safe.

Test Plan:
- Critical-word wrap: LINE_WORDS=4, INDEX_W=6, i_fill_addr=0x123 (tag 1, index 0x08, offset 3), ready always 1, rdata=0xA000_0000|o_mem_addr.
  - Required: cycle 1 tram write {0, 1} at index 0x08.
  - o_mem_addr sequence 0x123, 0x120, 0x121, 0x122.
  - o_dram_addr sequence 0x23, 0x20, 0x21, 0x22.
  - o_crit_valid in cycle 3 with data 0xA000_0123.
  - Cycle 10: tram write {1, 1} and o_fill_done.
- Wait states: ready low for 2 cycles in the first ADDR and 3 cycles in the first DATA.
  - Required: sel and addr stable while ready is low; no dram_we while ready is low; o_fill_done in cycle 15.
- Request while busy: second i_fill_req=1 with addr 0x3FF in cycle 5.
  - Required: address sequence and tag/index unchanged; single done pulse at cycle 10.
- Reset mid-fill: i_hreset=1 in cycle 6.
  - Required: cycle 7 all outputs 0 and no valid tag write.
  - A new request afterwards restarts with INVAL.
- Back-to-back: i_fill_req held at 1 with fixed addr 0x040.
  - Required: done at cycle 10, next INVAL at cycle 12, second done at cycle 21.
- LINE_WORDS=8, offset 7.
  - Required: offset order 7, 0, 1, …, 6; critical word is offset 7; done at cycle 18.
